// File: rtl/kvadd2_example_axi_mem_responder.sv
// AXI4 memory-mapped responder over one dual-port word array.
// Independent write (AW/W/B) and read (AR/R) FSMs, one burst outstanding each, INCR bursts only.
module kvadd2_example_axi_mem_responder #(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH        = 1024
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                        s_axi_awlen,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wlast,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                        s_axi_arlen,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic                              s_axi_rlast,
  output logic                              protocol_err
);

  localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;
  localparam int BYTE_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(C_MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  w_state_t w_state_r, w_state_nxt_s;
  r_state_t r_state_r, r_state_nxt_s;

  logic awready_r, wready_r, bvalid_r, arready_r, rvalid_r, rlast_r, protocol_err_r;
  logic awready_nxt_s, wready_nxt_s, bvalid_nxt_s, arready_nxt_s, rvalid_nxt_s, rlast_nxt_s;
  logic [IDX_W-1:0] w_idx_r, r_idx_r, rd_idx_s;
  logic [7:0]       w_len_r, w_cnt_r, r_len_r, r_cnt_r;
  logic             rd_en_s;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_r;
  logic [C_S_AXI_DATA_WIDTH-1:0] mem_r [C_MEM_DEPTH];

  logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, w_final_s, r_final_s;
  logic unused_addr_s;

  assign aw_hs_s   = s_axi_awvalid && awready_r;
  assign w_hs_s    = s_axi_wvalid && wready_r;
  assign b_hs_s    = bvalid_r && s_axi_bready;
  assign ar_hs_s   = s_axi_arvalid && arready_r;
  assign r_hs_s    = rvalid_r && s_axi_rready;
  assign w_final_s = (w_cnt_r == w_len_r);
  assign r_final_s = (r_cnt_r == r_len_r);
  assign unused_addr_s = ^{s_axi_awaddr, s_axi_araddr};

  // Write FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_r <= W_IDLE;
    end else begin
      w_state_r <= w_state_nxt_s;
    end
  end

  // Write FSM next state; the beat count alone ends the burst, wlast is only checked
  always_comb begin
    w_state_nxt_s = w_state_r;
    case (w_state_r)
      W_IDLE:  if (aw_hs_s) w_state_nxt_s = W_DATA;
               else w_state_nxt_s = W_IDLE;
      W_DATA:  if (w_hs_s && w_final_s) w_state_nxt_s = W_RESP;
               else w_state_nxt_s = W_DATA;
      W_RESP:  if (b_hs_s) w_state_nxt_s = W_IDLE;
               else w_state_nxt_s = W_RESP;
      default: w_state_nxt_s = W_IDLE;
    endcase
  end

  // Write-side handshake outputs for the coming cycle
  always_comb begin
    awready_nxt_s = (w_state_nxt_s == W_IDLE);
    wready_nxt_s  = (w_state_nxt_s == W_DATA);
    bvalid_nxt_s  = (w_state_nxt_s == W_RESP);
  end

  // Write burst tracking and sticky wlast/beat-count mismatch flag
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awready_r      <= 1'b0;
      wready_r       <= 1'b0;
      bvalid_r       <= 1'b0;
      w_idx_r        <= '0;
      w_len_r        <= 8'd0;
      w_cnt_r        <= 8'd0;
      protocol_err_r <= 1'b0;
    end else begin
      awready_r <= awready_nxt_s;
      wready_r  <= wready_nxt_s;
      bvalid_r  <= bvalid_nxt_s;
      if (aw_hs_s) begin
        w_idx_r <= s_axi_awaddr[BYTE_LSB +: IDX_W];
        w_len_r <= s_axi_awlen;
        w_cnt_r <= 8'd0;
      end else if (w_hs_s) begin
        w_idx_r <= w_idx_r + IDX_W'(1);
        w_cnt_r <= w_cnt_r + 8'd1;
      end
      if (w_hs_s && (s_axi_wlast != w_final_s)) begin
        protocol_err_r <= 1'b1;
      end
    end
  end

  // Memory write port with per-byte enables; contents are never reset
  always_ff @(posedge aclk) begin
    if (w_hs_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) begin
          mem_r[w_idx_r][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_r <= R_IDLE;
    end else begin
      r_state_r <= r_state_nxt_s;
    end
  end

  // Read FSM next state
  always_comb begin
    r_state_nxt_s = r_state_r;
    case (r_state_r)
      R_IDLE:  if (ar_hs_s) r_state_nxt_s = R_DATA;
               else r_state_nxt_s = R_IDLE;
      R_DATA:  if (r_hs_s && r_final_s) r_state_nxt_s = R_IDLE;
               else r_state_nxt_s = R_DATA;
      default: r_state_nxt_s = R_IDLE;
    endcase
  end

  // Read outputs and lookahead fetch: the word for the next beat is read on the handshake cycle
  always_comb begin
    arready_nxt_s = (r_state_nxt_s == R_IDLE);
    rvalid_nxt_s  = (r_state_nxt_s == R_DATA);
    if (ar_hs_s) begin
      rd_en_s     = 1'b1;
      rd_idx_s    = s_axi_araddr[BYTE_LSB +: IDX_W];
      rlast_nxt_s = (s_axi_arlen == 8'd0);
    end else if (r_hs_s && !r_final_s) begin
      rd_en_s     = 1'b1;
      rd_idx_s    = r_idx_r + IDX_W'(1);
      rlast_nxt_s = ((r_cnt_r + 8'd1) == r_len_r);
    end else if (r_hs_s) begin
      rd_en_s     = 1'b0;
      rd_idx_s    = r_idx_r;
      rlast_nxt_s = 1'b0;
    end else begin
      rd_en_s     = 1'b0;
      rd_idx_s    = r_idx_r;
      rlast_nxt_s = rlast_r;
    end
  end

  // Read burst tracking and handshake registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      r_idx_r   <= '0;
      r_len_r   <= 8'd0;
      r_cnt_r   <= 8'd0;
    end else begin
      arready_r <= arready_nxt_s;
      rvalid_r  <= rvalid_nxt_s;
      rlast_r   <= rlast_nxt_s;
      if (ar_hs_s) begin
        r_idx_r <= rd_idx_s;
        r_len_r <= s_axi_arlen;
        r_cnt_r <= 8'd0;
      end else if (r_hs_s && !r_final_s) begin
        r_idx_r <= rd_idx_s;
        r_cnt_r <= r_cnt_r + 8'd1;
      end
    end
  end

  // Memory read port; holding the enable low keeps rdata stable through stalls
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdata_r <= '0;
    end else if (rd_en_s) begin
      rdata_r <= mem_r[rd_idx_s];
    end
  end

  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_arready = arready_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rlast   = rlast_r;
  assign protocol_err  = protocol_err_r;

endmodule

// File: tb/tb_kvadd2_example_axi_mem_responder.sv
// Directed bench for the AXI memory responder: a word-level memory/handshake model is compared
// against the DUT every cycle, and literal read-back values pin the model.
module tb_kvadd2_example_axi_mem_responder;

  localparam int DW    = 512;
  localparam int DEPTH = 1024;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_axi_awvalid = 1'b0, s_axi_awready;
  logic [63:0]   s_axi_awaddr = '0;
  logic [7:0]    s_axi_awlen = '0;
  logic          s_axi_wvalid = 1'b0, s_axi_wready;
  logic [DW-1:0] s_axi_wdata = '0;
  logic [63:0]   s_axi_wstrb = '0;
  logic          s_axi_wlast = 1'b0;
  logic          s_axi_bvalid, s_axi_bready = 1'b0;
  logic          s_axi_arvalid = 1'b0, s_axi_arready;
  logic [63:0]   s_axi_araddr = '0;
  logic [7:0]    s_axi_arlen = '0;
  logic          s_axi_rvalid, s_axi_rready = 1'b0;
  logic [DW-1:0] s_axi_rdata;
  logic          s_axi_rlast;
  logic          protocol_err;

  kvadd2_example_axi_mem_responder dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast),
    .protocol_err(protocol_err)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model state: word memory plus handshake expectations for the coming cycle
  logic [DW-1:0] m_mem [int];
  bit m_awready = 0, m_wready = 0, m_bvalid = 0, m_arready = 0, m_rvalid = 0, m_err = 0;
  bit m_in_rst = 1;
  int m_widx, m_wlen, m_wcnt, m_ridx, m_rlen, m_rbeat;
  logic [DW-1:0] m_rdata = '0;
  int bcount = 0;
  logic [DW-1:0] got_q [$];
  logic [DW-1:0] wbuf [8];
  logic [63:0]   sbuf [8];

  function automatic int word_of(input logic [63:0] a);
    return int'((a / 64) % DEPTH);
  endfunction

  function automatic logic [DW-1:0] mem_get(input int i);
    if (m_mem.exists(i)) return m_mem[i];
    else return '0;
  endfunction

  // Per-cycle compare: check DUT against model, then advance model by this cycle's handshakes
  initial begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [DW-1:0] cur;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
        m_err = 0; m_in_rst = 1;
        check("rst_awready", s_axi_awready, 1'b0);
        check("rst_arready", s_axi_arready, 1'b0);
        check("rst_wready", s_axi_wready, 1'b0);
        check("rst_bvalid", s_axi_bvalid, 1'b0);
        check("rst_rvalid", s_axi_rvalid, 1'b0);
        check("rst_rlast", s_axi_rlast, 1'b0);
        check("rst_rdata", s_axi_rdata, '0);
        check("rst_protocol_err", protocol_err, 1'b0);
      end else begin
        check("awready", s_axi_awready, m_awready);
        check("wready", s_axi_wready, m_wready);
        check("bvalid", s_axi_bvalid, m_bvalid);
        check("arready", s_axi_arready, m_arready);
        check("rvalid", s_axi_rvalid, m_rvalid);
        check("rlast", s_axi_rlast, (m_rvalid && (m_rbeat == m_rlen)));
        check("protocol_err", protocol_err, m_err);
        if (m_rvalid) check("rdata", s_axi_rdata, m_rdata);
        if (m_in_rst) begin
          m_awready = 1; m_arready = 1; m_in_rst = 0;
        end else begin
          aw_hs = s_axi_awvalid && m_awready;
          w_hs  = s_axi_wvalid && m_wready;
          b_hs  = s_axi_bready && m_bvalid;
          ar_hs = s_axi_arvalid && m_arready;
          r_hs  = s_axi_rready && m_rvalid;
          // reads of this cycle see memory before this cycle's write
          if (r_hs) begin
            got_q.push_back(s_axi_rdata);
            if (m_rbeat == m_rlen) begin
              m_rvalid = 0; m_arready = 1;
            end else begin
              m_rbeat++;
              m_ridx  = (m_ridx + 1) % DEPTH;
              m_rdata = mem_get(m_ridx);
            end
          end
          if (ar_hs) begin
            m_arready = 0; m_rvalid = 1;
            m_ridx = word_of(s_axi_araddr); m_rlen = int'(s_axi_arlen); m_rbeat = 0;
            m_rdata = mem_get(m_ridx);
          end
          if (w_hs) begin
            cur = mem_get(m_widx);
            for (int b = 0; b < 64; b++) if (s_axi_wstrb[b]) cur[b*8 +: 8] = s_axi_wdata[b*8 +: 8];
            m_mem[m_widx] = cur;
            if (s_axi_wlast != (m_wcnt == m_wlen)) m_err = 1;
            if (m_wcnt == m_wlen) begin
              m_wready = 0; m_bvalid = 1;
            end else begin
              m_wcnt++;
              m_widx = (m_widx + 1) % DEPTH;
            end
          end
          if (b_hs) begin
            m_bvalid = 0; m_awready = 1; bcount++;
          end
          if (aw_hs) begin
            m_awready = 0; m_wready = 1;
            m_widx = word_of(s_axi_awaddr); m_wlen = int'(s_axi_awlen); m_wcnt = 0;
          end
        end
      end
    end
  end

  task automatic write_burst(input logic [63:0] addr, input int len, input int lastpos);
    int n;
    s_axi_awaddr = addr; s_axi_awlen = len[7:0]; s_axi_awvalid = 1'b1;
    n = 0; @(negedge aclk);
    while (!s_axi_awready && n < 50) begin @(negedge aclk); n++; end
    check("aw_wait", s_axi_awready, 1'b1);
    @(posedge aclk); #1 s_axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = wbuf[i]; s_axi_wstrb = sbuf[i];
      s_axi_wlast = (i == lastpos);
      n = 0; @(negedge aclk);
      while (!s_axi_wready && n < 50) begin @(negedge aclk); n++; end
      check("w_wait", s_axi_wready, 1'b1);
      @(posedge aclk); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
    n = 0; @(negedge aclk);
    while (!s_axi_bvalid && n < 50) begin @(negedge aclk); n++; end
    check("b_wait", s_axi_bvalid, 1'b1);
    @(posedge aclk); #1 s_axi_bready = 1'b0;
  endtask

  task automatic read_burst(input logic [63:0] addr, input int len, input int mode, input int delay);
    int n, got, k;
    repeat (delay) begin @(posedge aclk); #1; end
    s_axi_araddr = addr; s_axi_arlen = len[7:0]; s_axi_arvalid = 1'b1;
    n = 0; @(negedge aclk);
    while (!s_axi_arready && n < 50) begin @(negedge aclk); n++; end
    check("ar_wait", s_axi_arready, 1'b1);
    @(posedge aclk); #1 s_axi_arvalid = 1'b0;
    got = 0; k = 0;
    while (got <= len && k < 300) begin
      s_axi_rready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      @(negedge aclk);
      if (s_axi_rvalid && s_axi_rready) got++;
      @(posedge aclk); #1;
      k++;
    end
    s_axi_rready = 1'b0;
    check("r_beats", got, len + 1);
  endtask

  task automatic expect_words(input string name, input int n, input logic [DW-1:0] base);
    check({name, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) if (i < got_q.size()) check(name, got_q[i], base + i);
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < 8; i++) begin wbuf[i] = base + i; sbuf[i] = '1; end
  endtask

  initial begin
    int b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    check("awready_first_edge", s_axi_awready, 1'b1);
    check("arready_first_edge", s_axi_arready, 1'b1);

    // 4-beat write then read back at 0x40
    fill(512'd1); b0 = bcount;
    write_burst(64'h40, 3, 3);
    check("bvalid_once", bcount - b0, 1);
    got_q.delete();
    read_burst(64'h40, 3, 0, 0);
    expect_words("basic_read", 4, 512'd1);
    check("no_protocol_err", protocol_err, 1'b0);

    // partial strobe over an all-ones word
    wbuf[0] = '1; sbuf[0] = '1;
    write_burst(64'h200, 0, 0);
    wbuf[0] = {16{32'hDEAD_BEEF}}; sbuf[0] = 64'h0000_0000_0000_000F;
    write_burst(64'h200, 0, 0);
    got_q.delete();
    read_burst(64'h200, 0, 0, 0);
    check("strobe_merge", got_q.size() > 0 ? got_q[0] : '0, {{15{32'hFFFF_FFFF}}, 32'hDEAD_BEEF});

    // wrap from the last word to word 0; offset and upper address bits ignored
    fill(512'hAA);
    write_burst(64'hFFC0, 1, 1);
    got_q.delete(); read_burst(64'hFFC0, 1, 0, 0);
    expect_words("wrap_read", 2, 512'hAA);
    got_q.delete(); read_burst(64'h0, 0, 0, 0);
    expect_words("wrap_word0", 1, 512'hAB);
    got_q.delete(); read_burst(64'hF000_0000_0000_0047, 0, 0, 0);
    expect_words("addr_ignored_bits", 1, 512'd1);

    // 8-beat read with rready 1,0,0 pattern
    fill(512'h50);
    write_burst(64'h800, 7, 7);
    got_q.delete(); read_burst(64'h800, 7, 1, 0);
    expect_words("stall_read", 8, 512'h50);

    // concurrent write/read of the same words at three relative offsets
    fill(512'h100); write_burst(64'h400, 3, 3);
    fill(512'h200); got_q.delete(); b0 = bcount;
    fork write_burst(64'h400, 3, 3); read_burst(64'h400, 3, 0, 0); join
    expect_words("concurrent_ahead", 4, 512'h100);
    check("concurrent_bresp", bcount - b0, 1);
    fill(512'h300); got_q.delete();
    fork write_burst(64'h400, 3, 3); read_burst(64'h400, 3, 0, 1); join
    expect_words("concurrent_same_cycle", 4, 512'h200);
    fill(512'h400); got_q.delete();
    fork write_burst(64'h400, 3, 3); read_burst(64'h400, 3, 0, 2); join
    expect_words("concurrent_after", 4, 512'h400);

    // early wlast: burst still 4 beats, sticky error
    fill(512'h60); b0 = bcount;
    write_burst(64'h600, 3, 1);
    check("early_wlast_bresp", bcount - b0, 1);
    check("protocol_err_set", protocol_err, 1'b1);
    repeat (3) @(posedge aclk); #1;
    check("protocol_err_sticky", protocol_err, 1'b1);

    // reset during R_DATA
    s_axi_araddr = 64'h40; s_axi_arlen = 8'd7; s_axi_arvalid = 1'b1;
    @(negedge aclk); check("mid_ar_ready", s_axi_arready, 1'b1);
    @(posedge aclk); #1 s_axi_arvalid = 1'b0;
    repeat (2) @(posedge aclk); #1;
    check("mid_rvalid_before_rst", s_axi_rvalid, 1'b1);
    aresetn = 1'b0; #1;
    check("rvalid_drop_on_rst", s_axi_rvalid, 1'b0);
    check("err_clear_on_rst", protocol_err, 1'b0);
    @(posedge aclk); #1 aresetn = 1'b1;
    check("arready_held_low", s_axi_arready, 1'b0);
    @(posedge aclk); #1;
    check("arready_after_release", s_axi_arready, 1'b1);
    got_q.delete(); read_burst(64'h40, 3, 0, 0);
    expect_words("retained_after_rst", 4, 512'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/kvadd2_example_axi_mem_responder.md
KVADD2_EXAMPLE_AXI_MEM_RESPONDER -- requirements
Module: kvadd2_example_axi_mem_responder

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 64, byte-address width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 512, data width in bits; power of two, at least 32.
REQ-003 SHALL have parameter C_MEM_DEPTH, default 1024, memory depth in data words; power of two.
REQ-004 SHALL have one clock and an asynchronous active-low reset: aclk  in  1  sole clock, rising edge; aresetn  in  1  async assert, sync deassert externally.
REQ-005 SHALL have AW ports: s_axi_awvalid  in  1; s_axi_awready  out  1; s_axi_awaddr  in  ADDR; s_axi_awlen  in  8  beats-1.
REQ-006 SHALL have W ports: s_axi_wvalid  in  1; s_axi_wready  out  1; s_axi_wdata  in  DATA; s_axi_wstrb  in  DATA/8; s_axi_wlast  in  1.
REQ-007 SHALL have B ports: s_axi_bvalid  out  1; s_axi_bready  in  1 (response implicitly OKAY).
REQ-008 SHALL have AR ports: s_axi_arvalid  in  1; s_axi_arready  out  1; s_axi_araddr  in  ADDR; s_axi_arlen  in  8.
REQ-009 SHALL have R ports: s_axi_rvalid  out  1; s_axi_rready  in  1; s_axi_rdata  out  DATA; s_axi_rlast  out  1.
REQ-010 SHALL have protocol_err  out  1  sticky flag for a wlast/beat-count mismatch.

Function
REQ-011 SHALL compute word index = addr[LOG2(DATA/8) +: LOG2(C_MEM_DEPTH)]; lower offset bits and upper bits are ignored.
REQ-012 SHALL increment the word index by 1 per beat (INCR only), wrapping modulo C_MEM_DEPTH.
REQ-013 SHALL keep the write and read paths fully independent; each path has one burst outstanding.
REQ-014 Write FSM SHALL use states W_IDLE, W_DATA, W_RESP.
REQ-015 In W_IDLE, awready=1, wready=0, bvalid=0; on awvalid it SHALL latch address and awlen and go to W_DATA.
REQ-016 In W_DATA, wready=1; each wvalid beat SHALL write the bytes enabled by wstrb and leave other bytes unchanged.
REQ-017 On the beat where the count equals awlen, W_DATA SHALL go to W_RESP regardless of wlast.
REQ-018 SHALL set protocol_err if wlast=1 on a non-final beat or wlast=0 on the final beat; it clears only on reset.
REQ-019 In W_RESP, bvalid=1 SHALL hold until bready, then go to W_IDLE; awready stays 0 until then.
REQ-020 Read FSM SHALL use states R_IDLE, R_DATA.
REQ-021 In R_IDLE, arready=1, rvalid=0; on arvalid it SHALL latch the burst and go to R_DATA.
REQ-022 In R_DATA, rvalid=1 SHALL assert exactly 1 cycle after the AR handshake, with rdata valid from that cycle.
REQ-023 SHALL sustain one beat per cycle while rready=1, using a prefetch/lookahead read.
REQ-024 SHALL hold rdata, rlast and rvalid stable while rvalid=1 and rready=0.
REQ-025 SHALL assert rlast on beat awlen... arlen; the rlast handshake returns the FSM to R_IDLE.
REQ-026 Same-cycle read and write of the same word SHALL return the old data (read-before-write).
REQ-027 Read beats issued after a write beat's cycle SHALL see the new data.
REQ-028 Memory SHALL be a single dual-port array, one write port and one read port, inferable as BRAM; no reset of contents.
REQ-029 Handshakes SHALL follow AXI rules: no output depends combinationally on a valid input.
REQ-030 Ready outputs SHALL be registered or derived only from FSM state.

Reset
REQ-031 While aresetn=0, SHALL force both FSMs to idle and set awready=0, arready=0, wready=0, bvalid=0, rvalid=0, rlast=0, rdata=0, protocol_err=0.
REQ-032 Reset mid-burst SHALL abandon the burst; memory words already written SHALL be retained.
REQ-033 SHALL take awready and arready to 1 on the first rising aclk after aresetn deasserts.

Verification
REQ-034 Write awaddr=0x40, awlen=3, data 1..4, full strobes; then read araddr=0x40, arlen=3 -> rdata 1,2,3,4, rlast on beat 4, bvalid once, protocol_err=0.
REQ-035 Write one beat with wstrb=0x000...F over a word preloaded with 0xFF..FF -> read-back has bytes 0-3 from wdata and the rest 0xFF.
REQ-036 Address (C_MEM_DEPTH-1)*64, len=1 -> second beat lands at word 0; read-back matches.
REQ-037 Read len=7 with rready toggled 1,0,0,1,... -> no beat lost or duplicated, rdata stable while stalled.
REQ-038 Concurrent write and read burst to the same words -> both complete; write response and read data per REQ-026/027.
REQ-039 wlast=1 on beat 2 of a len=3 write -> burst still takes 4 beats, protocol_err=1 until aresetn pulse; reset during R_DATA -> rvalid=0 immediately, arready=1 after release.
